shift_unit: RTL and testbench

Parametrised multi-cycle shift/rotate unit, the successor to the single-cycle ALU shift path (SLL/SRL/SRA) of the RISC-V core. It shifts a W-bit operand by up to STEP bit positions per clock, so wide shifts trade latency for area. It adds ROL/ROR modes and valid/ready handshakes on both sides. It is intended for the multi-cycle and pipelined datapaths as an execute-stage functional unit.

---
 rtl/shift_unit.sv | 180 ++++++++++++++++++
 tb/tb_shift_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// ---------------------------------------------------------------------------
// shift_unit
//
// Multi-cycle shift/rotate execute unit. A request is accepted in IDLE. The
// operand is then shifted by at most STEP positions per clock until the
// requested amount is used up. The result is held until the consumer takes
// it. The unit supports SLL, SRL, SRA, ROL and ROR. An illegal op code is
// returned unchanged with op_err set.
//
// Parameters
//   W     operand width (power of two, >= 2)
//   STEP  maximum positions shifted per clock (1 .. W-1)
//   SW    shift-amount width, derived as $clog2(W)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   request present
//   in_ready   unit can accept a request (IDLE only)
//   op         0=SLL 1=SRL 2=SRA 3=ROL 4=ROR, 5..7 illegal
//   a          operand
//   shamt      shift amount, 0 .. W-1
//   out_valid  result held and valid (DONE)
//   out_ready  consumer accepts the result
//   result     shifted / rotated value (0 while out_valid is low)
//   op_err     qualifies result: the request op was illegal
// ---------------------------------------------------------------------------
module shift_unit #(
  parameter  int W    = 32,
  parameter  int STEP = 4,
  localparam int SW   = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [W-1:0]  a,
  input  logic [SW-1:0] shamt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result,
  output logic          op_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } op_e;

  localparam logic [SW-1:0] STEP_AMT = SW'(STEP);

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q,   acc_d;
  logic [SW-1:0] rem_q,   rem_d;
  logic [2:0]    op_q,    op_d;
  logic          op_err_q, op_err_d;

  logic          in_op_illegal;
  logic [SW-1:0] step_amt;
  logic [SW-1:0] rem_next;
  logic [W-1:0]  acc_stepped;
  logic [2*W-1:0] acc_dbl;
  logic [2*W-1:0] rol_dbl;
  logic [2*W-1:0] ror_dbl;

  assign in_op_illegal = (op > 3'd4);

  // The last step takes only what is left, so a shift never overshoots.
  assign step_amt = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
  assign rem_next = rem_q - step_amt;

  // Rotates are taken from a doubled copy of acc. Bits that leave one end
  // then come back in from the other end. This avoids a (W - k) term that
  // would be out of range when k = 0.
  assign acc_dbl = {acc_q, acc_q};
  assign rol_dbl = acc_dbl << step_amt;
  assign ror_dbl = acc_dbl >> step_amt;

  // One step of the selected operation on the accumulator. SRA fills from
  // acc's own MSB on every step, so the sign stays in place across steps.
  always_comb begin
    // NOTE: every always_comb output gets a default first. Without it, some
    // path leaves the signal unassigned and a latch is inferred.
    acc_stepped = acc_q;
    case (op_q)
      OP_SLL:  acc_stepped = acc_q << step_amt;
      OP_SRL:  acc_stepped = acc_q >> step_amt;
      OP_SRA:  acc_stepped = $signed(acc_q) >>> step_amt;
      OP_ROL:  acc_stepped = rol_dbl[2*W-1:W];
      OP_ROR:  acc_stepped = ror_dbl[W-1:0];
      default: acc_stepped = acc_q;
    endcase
  end

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      op_err_q <= 1'b0;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments only.
      // All flops then sample the same pre-edge values, whatever the order
      // of the statements.
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      op_err_q <= op_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_op_illegal || (shamt == '0)) state_d = S_DONE;
          else                                state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (rem_next == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    acc_d    = acc_q;
    rem_d    = rem_q;
    op_d     = op_q;
    op_err_d = op_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d    = a;
          rem_d    = shamt;
          op_d     = op;
          op_err_d = in_op_illegal;
        end
      end
      S_SHIFT: begin
        acc_d = acc_stepped;
        rem_d = rem_next;
      end
      S_DONE: begin
        if (out_ready) op_err_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs. These are decoded from the state only, so none of them has a
  // combinational path from the inputs.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    result    = out_valid ? acc_q : '0;
    op_err    = op_err_q;
  end

endmodule

// File: tb/tb_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_unit
//
// Five shift_unit instances run in lockstep from one stimulus stream:
//   cfg0 W=32 STEP=1, cfg1 W=32 STEP=3, cfg2 W=32 STEP=4,
//   cfg3 W=32 STEP=31, cfg4 W=8 STEP=3 (operand and shamt truncated).
// When an instance accepts a request, its monitor pushes the expected result
// and latency into its own queue. The expected values come from a bit-by-bit
// reference model. A directed vector may also carry hand-computed values for
// one chosen instance. The monitor pops an entry and compares it whenever
// its instance hands over a result.
// ---------------------------------------------------------------------------
module tb_shift_unit;

  localparam int NCFG = 5;

  function automatic int cfg_w(input int g);
    return (g == 4) ? 8 : 32;
  endfunction

  function automatic int cfg_step(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      3:       return 31;
      default: return 3;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  op;
  logic [31:0] a_drv;
  logic [4:0]  shamt_drv;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  bit          hand_en;
  int          hand_inst;
  logic [31:0] hand_res;
  bit          hand_err;
  int          hand_lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each result bit is picked straight from the source operand.
  function automatic logic [31:0] ref_model(input int w, input logic [2:0] o,
                                            input logic [31:0] av, input int sh);
    logic [31:0] am;
    logic [31:0] r;
    am = (w == 32) ? av : (av & ((32'd1 << w) - 32'd1));
    r  = '0;
    if (o > 3'd4) return am;
    for (int i = 0; i < w; i++) begin
      case (o)
        3'd0: r[i] = (i >= sh) ? am[i-sh] : 1'b0;
        3'd1: r[i] = (i + sh < w) ? am[i+sh] : 1'b0;
        3'd2: r[i] = (i + sh < w) ? am[i+sh] : am[w-1];
        3'd3: r[i] = am[(i - sh + w) % w];
        default: r[i] = am[(i + sh) % w];
      endcase
    end
    return r;
  endfunction

  function automatic int ref_lat(input int step, input int sh, input logic [2:0] o);
    if ((o > 3'd4) || (sh == 0)) return 1;
    return 1 + (sh + step - 1) / step;
  endfunction

  typedef struct {
    logic [31:0] res;
    bit          err;
    int          lat;
    int          c0;
    bit          hand;
    logic [31:0] h_res;
    bit          h_err;
    int          h_lat;
  } exp_t;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int GW    = cfg_w(g);
    localparam int GSTEP = cfg_step(g);
    localparam int GSW   = $clog2(GW);

    logic          rdy;
    logic          vld;
    logic          err;
    logic [GW-1:0] res;

    exp_t          exp_q[$];
    exp_t          e;
    bit            busy     = 1'b0;
    bit            seen     = 1'b0;
    bit            hold_chk = 1'b0;
    int            first_cyc = 0;
    int            pend_n    = 0;
    int            sh;
    logic [GW-1:0] held;

    shift_unit #(.W(GW), .STEP(GSTEP)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (rdy),
      .op        (op),
      .a         (a_drv[GW-1:0]),
      .shamt     (shamt_drv[GSW-1:0]),
      .out_valid (vld),
      .out_ready (out_ready),
      .result    (res),
      .op_err    (err)
    );

    initial forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        check($sformatf("cfg%0d reset {in_ready,out_valid,|result,op_err}", g),
              64'({rdy, vld, |res, err}), 64'(4'b1000));
        exp_q.delete();
        busy     = 1'b0;
        seen     = 1'b0;
        hold_chk = 1'b0;
      end else begin
        check($sformatf("cfg%0d in_ready", g), 64'(rdy), 64'(!busy));
        if (hold_chk) begin
          check($sformatf("cfg%0d held out_valid", g), 64'(vld), 64'(1'b1));
          check($sformatf("cfg%0d held result", g), 64'(res), 64'(held));
          if (!vld) hold_chk = 1'b0;
        end
        if (vld) begin
          if (!seen) begin
            seen      = 1'b1;
            first_cyc = cyc;
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              check($sformatf("cfg%0d unexpected result", g), 64'(1), 64'(0));
            end else begin
              e = exp_q.pop_front();
              check($sformatf("cfg%0d result", g), 64'(res), 64'(e.res));
              check($sformatf("cfg%0d op_err", g), 64'(err), 64'(e.err));
              check($sformatf("cfg%0d latency", g), 64'(first_cyc - e.c0 + 1), 64'(e.lat));
              if (e.hand) begin
                check($sformatf("cfg%0d hand result", g), 64'(res), 64'(e.h_res));
                check($sformatf("cfg%0d hand op_err", g), 64'(err), 64'(e.h_err));
                check($sformatf("cfg%0d hand latency", g), 64'(first_cyc - e.c0 + 1), 64'(e.h_lat));
              end
            end
            busy     = 1'b0;
            seen     = 1'b0;
            hold_chk = 1'b0;
          end else if (!hold_chk) begin
            hold_chk = 1'b1;
            held     = res;
          end
        end
        // The request is taken on the coming rising edge.
        if (in_valid && rdy) begin
          sh      = int'(shamt_drv) % GW;
          e.res   = ref_model(GW, op, a_drv, sh);
          e.err   = (op > 3'd4);
          e.lat   = ref_lat(GSTEP, sh, op);
          e.c0    = cyc + 1;
          e.hand  = hand_en && (hand_inst == g);
          e.h_res = hand_res;
          e.h_err = hand_err;
          e.h_lat = hand_lat;
          exp_q.push_back(e);
          busy = 1'b1;
        end
      end
      pend_n = exp_q.size();
    end
  end

  logic all_rdy;
  logic all_vld;
  assign all_rdy = g_cfg[0].rdy & g_cfg[1].rdy & g_cfg[2].rdy & g_cfg[3].rdy & g_cfg[4].rdy;
  assign all_vld = g_cfg[0].vld & g_cfg[1].vld & g_cfg[2].vld & g_cfg[3].vld & g_cfg[4].vld;

  // Called at a falling edge; returns at a falling edge.
  task automatic wait_idle();
    int t = 0;
    while (!all_rdy && (t < 200)) begin
      @(negedge clk);
      t++;
    end
    if (!all_rdy) check("wait for in_ready", 64'(0), 64'(1));
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input int sh,
                       input int hi, input logic [31:0] hr, input bit he, input int hl);
    wait_idle();
    op        = o;
    a_drv     = av;
    shamt_drv = 5'(sh);
    hand_en   = (hi >= 0);
    hand_inst = hi;
    hand_res  = hr;
    hand_err  = he;
    hand_lat  = hl;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    hand_en   = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = '0;
    a_drv     = '0;
    shamt_drv = '0;
    hand_en   = 1'b0;
    hand_inst = -1;
    hand_res  = '0;
    hand_err  = 1'b0;
    hand_lat  = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Directed vectors: op, a, shamt, instance, hand result, hand op_err, hand latency.
    issue(3'd2, 32'hffff_fff8,  2, 2, 32'hffff_fffe, 1'b0, 2);
    issue(3'd2, 32'h0000_0008,  2, 2, 32'h0000_0002, 1'b0, 2);
    issue(3'd1, 32'h8000_0000, 31, 2, 32'h0000_0001, 1'b0, 9);
    issue(3'd4, 32'h0000_00f1,  4, 2, 32'h1000_000f, 1'b0, 2);
    issue(3'd3, 32'h8000_0001,  1, 2, 32'h0000_0003, 1'b0, 2);
    issue(3'd0, 32'h0000_0008,  0, 2, 32'h0000_0008, 1'b0, 1);
    issue(3'd6, 32'h1234_5678,  9, 2, 32'h1234_5678, 1'b1, 1);
    issue(3'd2, 32'h0000_0080,  7, 4, 32'h0000_00ff, 1'b0, 4);
    issue(3'd1, 32'h0000_0080,  7, 4, 32'h0000_0001, 1'b0, 4);

    // Backpressure: results held for 5 cycles while request pulses are ignored.
    wait_idle();
    out_ready = 1'b0;
    issue(3'd4, 32'h0000_00f1, 4, 2, 32'h1000_000f, 1'b0, 2);
    begin
      int t = 0;
      while (!all_vld && (t < 100)) begin
        @(negedge clk);
        t++;
      end
      if (!all_vld) check("wait for out_valid", 64'(0), 64'(1));
    end
    for (int i = 0; i < 5; i++) begin
      op       = 3'(i % 5);
      a_drv    = $urandom;
      in_valid = (i % 2 == 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    issue(3'd0, 32'h0000_0001, 3, 2, 32'h0000_0008, 1'b0, 2);

    // Reset in the middle of a long shift.
    issue(3'd1, 32'h8000_0000, 31, -1, '0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("cfg0 async reset", 64'({g_cfg[0].rdy, g_cfg[0].vld, |g_cfg[0].res, g_cfg[0].err}), 64'(4'b1000));
    check("cfg2 async reset", 64'({g_cfg[2].rdy, g_cfg[2].vld, |g_cfg[2].res, g_cfg[2].err}), 64'(4'b1000));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(3'd0, 32'h0000_00a5, 4, 2, 32'h0000_0a50, 1'b0, 2);

    // Sweep of every legal op and shift amount with random operands.
    for (int s = 0; s < 32; s++) begin
      for (int o = 0; o < 5; o++) begin
        issue(3'(o), $urandom, s, -1, '0, 1'b0, 0);
      end
    end
    issue(3'd5, $urandom, 17, -1, '0, 1'b0, 0);
    issue(3'd7, $urandom,  0, -1, '0, 1'b0, 0);

    wait_idle();
    repeat (3) @(negedge clk);
    check("pending results", 64'(g_cfg[0].pend_n + g_cfg[1].pend_n + g_cfg[2].pend_n +
                                 g_cfg[3].pend_n + g_cfg[4].pend_n), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
